// File: rtl/cnt_pkg.sv
// Shared types and constants for the mode_counter family of counters.
package cnt_pkg;

    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_e;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    localparam int CNT_MIN_WIDTH = 2;

endpackage

// File: rtl/cnt_prescaler.sv
// Divide-by-PRESCALE enable prescaler: tick is high on the en cycle that
// completes a PRESCALE-long group of enabled cycles.
module cnt_prescaler
    import cnt_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] TERM = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_r;
    logic [PW-1:0] cnt_nxt_s;
    logic          at_term_s;

    assign at_term_s = (cnt_r == TERM);
    assign tick      = en & at_term_s;

    // Next prescaler phase: clear wins, otherwise advance on en and fold at the terminal phase
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = {PW{1'b0}};
        end else if (en && at_term_s) begin
            cnt_nxt_s = {PW{1'b0}};
        end else if (en) begin
            cnt_nxt_s = cnt_r + PW'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Prescaler phase register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {PW{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

endmodule

// File: rtl/mode_counter.sv
// Parametrised up/down counter with programmable terminal value, wrap/saturate
// mode, sync clear/load and event flags. Optional prescaler: CNT_PRESCALER_EN.
module mode_counter
    import cnt_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] out,
    output logic             at_max,
    output logic             at_zero,
    output logic             wrap,
    output logic             sat
);

    logic [WIDTH-1:0] out_r;
    logic             wrap_r;
    logic             sat_r;
    logic [WIDTH-1:0] out_nxt_s;
    logic             wrap_nxt_s;
    logic             sat_nxt_s;
    logic             cstep_s;
    cnt_dir_e         dir_s;
    cnt_mode_e        mode_s;

`ifdef CNT_PRESCALER_EN
    cnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (clr | load),
        .tick (cstep_s)
    );
`else
    logic unused_prescale_s;
    assign unused_prescale_s = PRESCALE[0];
    assign cstep_s           = en;
`endif

    assign dir_s  = cnt_dir_e'(up);
    assign mode_s = cnt_mode_e'(sat_mode);

    // Next count and event flags; sat stays sticky unless clr or load clears it
    always_comb begin
        out_nxt_s  = out_r;
        wrap_nxt_s = 1'b0;
        sat_nxt_s  = sat_r;
        if (clr) begin
            out_nxt_s = {WIDTH{1'b0}};
            sat_nxt_s = 1'b0;
        end else if (load) begin
            if (load_val > max_val) begin
                out_nxt_s = max_val;
            end else begin
                out_nxt_s = load_val;
            end
            sat_nxt_s = 1'b0;
        end else if (cstep_s) begin
            case (dir_s)
                CNT_UP: begin
                    if (out_r < max_val) begin
                        out_nxt_s = out_r + WIDTH'(1);
                    end else if (mode_s == CNT_SAT) begin
                        out_nxt_s = max_val;
                        sat_nxt_s = 1'b1;
                    end else begin
                        out_nxt_s  = {WIDTH{1'b0}};
                        wrap_nxt_s = 1'b1;
                    end
                end
                CNT_DOWN: begin
                    // A count left above a lowered max_val snaps back into range
                    if (out_r > max_val) begin
                        out_nxt_s = max_val;
                    end else if (out_r != {WIDTH{1'b0}}) begin
                        out_nxt_s = out_r - WIDTH'(1);
                    end else if (mode_s == CNT_SAT) begin
                        out_nxt_s = {WIDTH{1'b0}};
                        sat_nxt_s = 1'b1;
                    end else begin
                        out_nxt_s  = max_val;
                        wrap_nxt_s = 1'b1;
                    end
                end
                default: begin
                    out_nxt_s = out_r;
                end
            endcase
        end else begin
            out_nxt_s = out_r;
        end
    end

    // Count and event flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r  <= {WIDTH{1'b0}};
            wrap_r <= 1'b0;
            sat_r  <= 1'b0;
        end else begin
            out_r  <= out_nxt_s;
            wrap_r <= wrap_nxt_s;
            sat_r  <= sat_nxt_s;
        end
    end

    assign out     = out_r;
    assign wrap    = wrap_r;
    assign sat     = sat_r;
    assign at_max  = (out_r >= max_val);
    assign at_zero = (out_r == {WIDTH{1'b0}});

endmodule
